// File: rtl/branch_condition_unit.sv
// Evaluates a 4-bit branch condition against O/S/C/Z once no flag write is pending.
// Latency: one cycle from accepted REQ to DONE when W_RF stays quiet; each flag write restarts the quiet window.
// Backpressure: REQ is ignored while BUSY; REQ in the DONE cycle is accepted (no queueing).
module branch_condition_unit #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic [3:0] COND,
  input  logic       in_O,
  input  logic       in_S,
  input  logic       in_C,
  input  logic       in_Z,
  input  logic [2:0] W_RF,
  output logic       BUSY,
  output logic       DONE,
  output logic       TAKEN
);

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EVAL = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] cond_q;
  logic       flag_write;
  logic       cond_hit;

  assign flag_write = (W_RF != 3'b000);

  // BUSY is decoded straight from the state register.
  assign BUSY = (state != ST_IDLE);

  // Condition decode; X = S^O is the signed less-than indicator.
  always_comb begin
    logic lt;
    lt       = in_S ^ in_O;
    cond_hit = 1'b0;
    case (cond_q)
      4'b0000: cond_hit = 1'b1;
      4'b0001: cond_hit = in_Z;
      4'b0010: cond_hit = ~in_Z;
      4'b0011: cond_hit = in_S;
      4'b0100: cond_hit = ~in_S;
      4'b0101: cond_hit = in_C;
      4'b0110: cond_hit = ~in_C;
      4'b0111: cond_hit = in_O;
      4'b1000: cond_hit = ~in_O;
      4'b1001: cond_hit = lt;
      4'b1010: cond_hit = ~lt;
      4'b1011: cond_hit = ~in_Z & ~lt;
      4'b1100: cond_hit = in_Z | lt;
      4'b1101: cond_hit = in_C & ~in_Z;
      4'b1110: cond_hit = ~in_C | in_Z;
      default: cond_hit = 1'b0;
    endcase
  end

  // Request sequencing: hold off sampling until the flag register has been quiet long enough.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      cnt    <= 3'd0;
      cond_q <= 4'd0;
      DONE   <= 1'b0;
      TAKEN  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (REQ) begin
            cond_q <= COND;
            if (flag_write) begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end else begin
              state <= ST_EVAL;
            end
          end
        end
        ST_WAIT: begin
          if (flag_write) begin
            cnt <= WAIT_LOAD;
          end else if (cnt == 3'd1) begin
            state <= ST_EVAL;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_EVAL: begin
          // A write landing this edge would make the sampled flags stale, so back off.
          if (flag_write) begin
            state <= ST_WAIT;
            cnt   <= WAIT_LOAD;
          end else begin
            TAKEN <= cond_hit;
            DONE  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_condition_unit.sv
// Directed and randomized checking of branch_condition_unit against a timestamp-based reference.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: the reference only accepts a request when it believes the unit is idle.
module tb_branch_condition_unit;

  localparam int WC = 1;

  logic       clk;
  logic       rst;
  logic       req;
  logic [3:0] cond;
  logic       f_o, f_s, f_c, f_z;
  logic [2:0] w_rf;
  logic       busy, done, taken;

  int checks   = 0;
  int failures = 0;

  // reference state: a pending request and the edge of the most recent flag write
  int   cyc     = 0;
  bit   m_busy  = 0;
  logic [3:0] m_cond = 4'd0;
  int   m_last  = 0;
  logic m_done  = 1'b0;
  logic m_taken = 1'b0;

  branch_condition_unit #(.WAIT_CYCLES(WC)) dut (
    .CLK   (clk),
    .RST   (rst),
    .REQ   (req),
    .COND  (cond),
    .in_O  (f_o),
    .in_S  (f_s),
    .in_C  (f_c),
    .in_Z  (f_z),
    .W_RF  (w_rf),
    .BUSY  (busy),
    .DONE  (done),
    .TAKEN (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // branch decision straight from the condition table; signed less-than is N != V
  function automatic logic ref_f(input logic [3:0] c, input logic [3:0] fl);
    logic o, s, cy, z, lt;
    o = fl[3]; s = fl[2]; cy = fl[1]; z = fl[0];
    lt = (s != o);
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return s;
      4'd4:  return !s;
      4'd5:  return cy;
      4'd6:  return !cy;
      4'd7:  return o;
      4'd8:  return !o;
      4'd9:  return lt;
      4'd10: return !lt;
      4'd11: return !(z || lt);
      4'd12: return z || lt;
      4'd13: return cy && !z;
      4'd14: return !cy || z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, advance the reference, then compare all outputs
  task automatic step(input logic r_req, input logic [3:0] r_cond, input logic [3:0] fl,
                      input logic [2:0] r_w, input logic r_rst);
    req  = r_req;
    cond = r_cond;
    {f_o, f_s, f_c, f_z} = fl;
    w_rf = r_w;
    rst  = r_rst;
    @(posedge clk);
    cyc++;
    m_done = 1'b0;
    if (r_rst) begin
      m_busy  = 0;
      m_taken = 1'b0;
    end else if (!m_busy) begin
      if (r_req) begin
        m_busy = 1;
        m_cond = r_cond;
        // no write at acceptance behaves as if the last write were long enough ago
        m_last = (r_w != 3'b000) ? cyc : cyc - WC;
      end
    end else if (r_w != 3'b000) begin
      m_last = cyc;
    end else if (cyc - m_last >= WC + 1) begin
      m_done  = 1'b1;
      m_taken = ref_f(m_cond, fl);
      m_busy  = 0;
    end
    #1;
    chk("model_done",  done,  m_done);
    chk("model_busy",  busy,  logic'(m_busy));
    chk("model_taken", taken, m_taken);
  endtask

  task automatic run_req(input string tag, input logic [3:0] c, input logic [3:0] fl,
                         input logic exp_taken);
    step(1'b1, c, fl, 3'b000, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
    step(1'b0, c, fl, 3'b000, 1'b0);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_taken"}, taken, exp_taken);
  endtask

  initial begin
    logic [3:0] fl;
    // reset
    step(1'b0, 4'd0, 4'd0, 3'b000, 1'b1);
    step(1'b0, 4'd0, 4'd0, 3'b000, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_taken", taken, 1'b0);
    step(1'b0, 4'd0, 4'd0, 3'b000, 1'b0);

    // Z set: equal / not-equal
    run_req("eq_z", 4'b0001, 4'b0001, 1'b1);
    run_req("ne_z", 4'b0010, 4'b0001, 1'b0);

    // signed comparisons
    run_req("lt_s1o0", 4'b1001, 4'b0100, 1'b1);
    run_req("lt_s1o1", 4'b1001, 4'b1100, 1'b0);
    run_req("gt_z",    4'b1011, 4'b0001, 1'b0);
    run_req("le_z",    4'b1100, 4'b0001, 1'b1);

    // write in the request cycle: DONE two edges later using post-write flags
    step(1'b1, 4'b0001, 4'b0000, 3'b011, 1'b0);
    step(1'b0, 4'b0000, 4'b0001, 3'b000, 1'b0);
    chk("wr_req_early", done, 1'b0);
    step(1'b0, 4'b0000, 4'b0001, 3'b000, 1'b0);
    chk("wr_req_done", done, 1'b1);
    chk("wr_req_taken", taken, 1'b1);

    // write during EVAL backs off, then three writes in WAIT
    step(1'b1, 4'b0101, 4'b0000, 3'b000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 3'b100, 1'b0);
    chk("eval_wr_nodone", done, 1'b0);
    chk("eval_wr_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0000, 4'b0000, 3'b100, 1'b0);
      chk("wait_wr_nodone", done, 1'b0);
    end
    for (int i = 0; i < WC; i++) begin
      step(1'b0, 4'b0000, 4'b0010, 3'b000, 1'b0);
      chk("wait_quiet_nodone", done, 1'b0);
    end
    step(1'b0, 4'b0000, 4'b0010, 3'b000, 1'b0);
    chk("wait_done", done, 1'b1);
    chk("wait_taken", taken, 1'b1);

    // REQ while busy is ignored; REQ in DONE cycle is accepted
    step(1'b1, 4'b0000, 4'b0000, 3'b001, 1'b0);
    step(1'b1, 4'b1111, 4'b0000, 3'b000, 1'b0);
    chk("busy_req_nodone", done, 1'b0);
    step(1'b1, 4'b1111, 4'b0000, 3'b000, 1'b0);
    chk("busy_req_done", done, 1'b1);
    chk("busy_req_taken", taken, 1'b1);
    step(1'b1, 4'b1111, 4'b0000, 3'b000, 1'b0);
    chk("b2b_accept_nodone", done, 1'b0);
    chk("b2b_accept_busy", busy, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, 3'b000, 1'b0);
    chk("b2b_done", done, 1'b1);
    chk("b2b_taken", taken, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 3'b000, 1'b0);
    chk("b2b_single", done, 1'b0);

    // reset while waiting aborts the request
    run_req("pre_rst", 4'b0000, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 3'b010, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 3'b000, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_taken", taken, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0000, 4'b0000, 3'b000, 1'b0);
      chk("abort_nodone", done, 1'b0);
    end

    // always / never over every flag combination
    for (int i = 0; i < 16; i++) begin
      fl = 4'(i);
      run_req("always", 4'b0000, fl, 1'b1);
      run_req("never",  4'b1111, fl, 1'b0);
    end

    // random traffic against the reference
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 2) == 0),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
           ($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
